// File: rtl/manta_mem_arbiter_if.sv
// ============================================================================
// Module   : manta_mem_arbiter_if
// Brief    : Requester (IF/DM) and memory-side signal bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface manta_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              eot;

    // The arbiter sits on the slave side of this bundle.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, eot
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, eot
    );
endinterface

`default_nettype wire

// File: rtl/manta_mem_arbiter.sv
// ============================================================================
// Module   : manta_mem_arbiter
// Brief    : Two-port (fetch / load-store) arbiter and sequencer for a
//            single-ported memory, with sticky end-of-test store detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module manta_mem_arbiter #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                MEM_LAT    = 1,
    parameter int                STARVE_MAX = 3,
    parameter logic [ADDR_W-1:0] EOT_ADDR   = 16'hd074,
    parameter logic [DATA_W-1:0] EOT_DATA   = 16'hd074
) (
    input  logic                   clk,
    input  logic                   rst_n,
    manta_mem_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam logic [2:0] c_LAT_LAST   = 3'(MEM_LAT - 1);
    localparam logic [1:0] c_STARVE_MAX = 2'(STARVE_MAX);

    state_t            r_state,     w_state_nxt;
    logic [2:0]        r_lat_cnt,   w_lat_cnt_nxt;
    logic [1:0]        r_starve,    w_starve_nxt;
    logic              r_win_dm,    w_win_dm_nxt;
    logic              r_if_gnt,    w_if_gnt_nxt;
    logic              r_dm_gnt,    w_dm_gnt_nxt;
    logic              r_if_rvalid, w_if_rvalid_nxt;
    logic              r_dm_rvalid, w_dm_rvalid_nxt;
    logic              r_mem_en,    w_mem_en_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic              r_eot,       w_eot_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_W-1:0] r_dm_rdata,  w_dm_rdata_nxt;

    logic w_dm_wins;
    logic w_eot_hit;

    // DM (older instruction) wins contention unless IF has been starved long enough.
    assign w_dm_wins = bus.dm_req & ~(bus.if_req & (r_starve == c_STARVE_MAX));

    // mem_we is only ever high during a DM store ACCESS cycle.
    assign w_eot_hit = r_win_dm & r_mem_we
                     & (r_mem_addr == EOT_ADDR) & (r_mem_wdata == EOT_DATA);

    always_comb begin
        w_state_nxt     = r_state;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_starve_nxt    = r_starve;
        w_win_dm_nxt    = r_win_dm;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_eot_nxt       = r_eot;
        w_if_gnt_nxt    = 1'b0;
        w_dm_gnt_nxt    = 1'b0;
        w_if_rvalid_nxt = 1'b0;
        w_dm_rvalid_nxt = 1'b0;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    w_state_nxt  = ST_ACCESS;
                    w_mem_en_nxt = 1'b1;
                    w_win_dm_nxt = w_dm_wins;
                    if (w_dm_wins) begin
                        w_dm_gnt_nxt    = 1'b1;
                        w_mem_we_nxt    = bus.dm_we;
                        w_mem_addr_nxt  = bus.dm_addr;
                        w_mem_wdata_nxt = bus.dm_wdata;
                        if (bus.if_req && (r_starve != c_STARVE_MAX)) begin
                            w_starve_nxt = r_starve + 2'd1;
                        end
                    end else begin
                        w_if_gnt_nxt   = 1'b1;
                        w_mem_addr_nxt = bus.if_addr;
                        w_starve_nxt   = 2'd0;
                    end
                end
            end

            ST_ACCESS: begin
                if (r_mem_we) begin
                    w_state_nxt = ST_IDLE;
                    w_eot_nxt   = r_eot | w_eot_hit;
                end else begin
                    w_state_nxt   = ST_WAIT;
                    w_lat_cnt_nxt = c_LAT_LAST;
                end
            end

            ST_WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_state_nxt = ST_IDLE;
                    if (r_win_dm) begin
                        w_dm_rvalid_nxt = 1'b1;
                        w_dm_rdata_nxt  = bus.mem_rdata;
                    end else begin
                        w_if_rvalid_nxt = 1'b1;
                        w_if_rdata_nxt  = bus.mem_rdata;
                    end
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - 3'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lat_cnt   <= 3'd0;
            r_starve    <= 2'd0;
            r_win_dm    <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_eot       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_starve    <= w_starve_nxt;
            r_win_dm    <= w_win_dm_nxt;
            r_if_gnt    <= w_if_gnt_nxt;
            r_dm_gnt    <= w_dm_gnt_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_dm_rvalid <= w_dm_rvalid_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_eot       <= w_eot_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_gnt    = r_dm_gnt;
    assign bus.dm_rvalid = r_dm_rvalid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.eot       = r_eot;

endmodule

`default_nettype wire

// File: tb/tb_manta_mem_arbiter.sv
// ============================================================================
// Module   : tb_manta_mem_arbiter
// Brief    : Directed self-checking bench for manta_mem_arbiter (MEM_LAT 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_manta_mem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    manta_mem_arbiter_if b1 ();
    manta_mem_arbiter_if b3 ();

    manta_mem_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    manta_mem_arbiter #(.MEM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    always #5 clk = ~clk;

    // Shared memory; read data is only meaningful in the cycle MEM_LAT after mem_en.
    logic [15:0] mem [256];
    logic        p1_v;
    logic [15:0] p1_d;
    logic [2:0]  p3_v;
    logic [15:0] p3_d [3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'ha000 + 16'(i);
        mem[4] = 16'h1234;
        p1_v = 1'b0;
        p3_v = 3'b000;
    end

    always @(posedge clk) begin
        if (b1.mem_en && b1.mem_we) mem[b1.mem_addr[7:0]] <= b1.mem_wdata;
        p1_v    <= b1.mem_en && !b1.mem_we;
        p1_d    <= mem[b1.mem_addr[7:0]];
        p3_v    <= {p3_v[1:0], b3.mem_en && !b3.mem_we};
        p3_d[0] <= mem[b3.mem_addr[7:0]];
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end

    assign b1.mem_rdata = p1_v    ? p1_d    : 16'hdead;
    assign b3.mem_rdata = p3_v[2] ? p3_d[2] : 16'hdead;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dm_store(input logic [15:0] addr, input logic [15:0] data);
        b1.dm_req   = 1'b1;
        b1.dm_we    = 1'b1;
        b1.dm_addr  = addr;
        b1.dm_wdata = data;
        tick();
        chk("store_gnt", b1.dm_gnt, 1);
        chk("store_we", b1.mem_we, 1);
        b1.dm_req = 1'b0;
        b1.dm_we  = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        is_dm;
        logic [15:0] exp_if_rd;
        logic [15:0] exp_dm_rd;

        b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
        b1.dm_addr = '0;  b1.dm_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.dm_req = 1'b0; b3.dm_we = 1'b0;
        b3.dm_addr = '0;  b3.dm_wdata = '0;

        // Reset then idle
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_mem_en",    b1.mem_en, 0);
        chk("rst_mem_we",    b1.mem_we, 0);
        chk("rst_mem_addr",  b1.mem_addr, 0);
        chk("rst_mem_wdata", b1.mem_wdata, 0);
        chk("rst_if_gnt",    b1.if_gnt, 0);
        chk("rst_dm_gnt",    b1.dm_gnt, 0);
        chk("rst_if_rvalid", b1.if_rvalid, 0);
        chk("rst_dm_rvalid", b1.dm_rvalid, 0);
        chk("rst_if_rdata",  b1.if_rdata, 0);
        chk("rst_dm_rdata",  b1.dm_rdata, 0);
        chk("rst_eot",       b1.eot, 0);
        chk("rst3_mem_en",   b3.mem_en, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_mem_en", b1.mem_en, 0);
            chk("idle_gnt", {b1.if_gnt, b1.dm_gnt}, 0);
        end

        // IF read, MEM_LAT=1
        b1.if_req = 1'b1; b1.if_addr = 16'h0004;
        tick();
        chk("ifrd_gnt",    b1.if_gnt, 1);
        chk("ifrd_mem_en", b1.mem_en, 1);
        chk("ifrd_addr",   b1.mem_addr, 16'h0004);
        chk("ifrd_we",     b1.mem_we, 0);
        chk("ifrd_dm_gnt", b1.dm_gnt, 0);
        b1.if_req = 1'b0;
        tick();
        chk("ifrd_gnt_drop", b1.if_gnt, 0);
        chk("ifrd_en_drop",  b1.mem_en, 0);
        chk("ifrd_rv_early", b1.if_rvalid, 0);
        tick();
        chk("ifrd_rvalid", b1.if_rvalid, 1);
        chk("ifrd_rdata",  b1.if_rdata, 16'h1234);
        chk("ifrd_dm_rv",  b1.dm_rvalid, 0);
        tick();
        chk("ifrd_rv_pulse", b1.if_rvalid, 0);
        chk("ifrd_rdata_hold", b1.if_rdata, 16'h1234);

        // DM store, then back-to-back store two cycles later
        b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 16'h0100; b1.dm_wdata = 16'hbeef;
        tick();
        chk("st_gnt",   b1.dm_gnt, 1);
        chk("st_en",    b1.mem_en, 1);
        chk("st_we",    b1.mem_we, 1);
        chk("st_addr",  b1.mem_addr, 16'h0100);
        chk("st_wdata", b1.mem_wdata, 16'hbeef);
        chk("st_if_gnt", b1.if_gnt, 0);
        b1.dm_addr = 16'h0101; b1.dm_wdata = 16'h5555;
        tick();
        chk("st_en_drop",    b1.mem_en, 0);
        chk("st_we_drop",    b1.mem_we, 0);
        chk("st_gnt_drop",   b1.dm_gnt, 0);
        chk("st_addr_hold",  b1.mem_addr, 16'h0100);
        chk("st_wdata_hold", b1.mem_wdata, 16'hbeef);
        chk("st_no_rvalid",  b1.dm_rvalid, 0);
        tick();
        chk("st2_gnt",   b1.dm_gnt, 1);
        chk("st2_addr",  b1.mem_addr, 16'h0101);
        chk("st2_wdata", b1.mem_wdata, 16'h5555);
        b1.dm_req = 1'b0; b1.dm_we = 1'b0;
        tick();
        chk("st2_no_rvalid", b1.dm_rvalid, 0);

        // DM load of the stored word
        b1.dm_req = 1'b1; b1.dm_addr = 16'h0100;
        tick();
        chk("ld_gnt", b1.dm_gnt, 1);
        chk("ld_we",  b1.mem_we, 0);
        b1.dm_req = 1'b0;
        tick();
        tick();
        chk("ld_rvalid",  b1.dm_rvalid, 1);
        chk("ld_rdata",   b1.dm_rdata, 16'hbeef);
        chk("ld_if_hold", b1.if_rdata, 16'h1234);

        // Contention: grant order DM,DM,DM,IF repeating
        exp_if_rd = 16'h1234;
        exp_dm_rd = 16'hbeef;
        b1.if_req = 1'b1; b1.if_addr = 16'h0010;
        b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 16'h0020;
        for (int k = 0; k < 8; k++) begin
            is_dm = ((k % 4) != 3);
            tick();
            chk("cont_dm_gnt", b1.dm_gnt, is_dm);
            chk("cont_if_gnt", b1.if_gnt, !is_dm);
            chk("cont_addr", b1.mem_addr, is_dm ? 16'h0020 : 16'h0010);
            tick();
            tick();
            if (is_dm) exp_dm_rd = 16'ha020;
            else       exp_if_rd = 16'ha010;
            chk("cont_dm_rvalid", b1.dm_rvalid, is_dm);
            chk("cont_if_rvalid", b1.if_rvalid, !is_dm);
            chk("cont_dm_rdata",  b1.dm_rdata, exp_dm_rd);
            chk("cont_if_rdata",  b1.if_rdata, exp_if_rd);
        end
        b1.if_req = 1'b0; b1.dm_req = 1'b0;

        // End-of-test detection
        dm_store(16'hd073, 16'hd074);
        chk("eot_wrong_addr", b1.eot, 0);
        dm_store(16'hd074, 16'h1111);
        chk("eot_wrong_data", b1.eot, 0);
        b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 16'hd074;
        tick();
        b1.dm_req = 1'b0;
        tick();
        tick();
        chk("eot_load", b1.eot, 0);
        b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 16'hd074; b1.dm_wdata = 16'hd074;
        tick();
        chk("eot_in_access", b1.eot, 0);
        b1.dm_req = 1'b0; b1.dm_we = 1'b0;
        tick();
        chk("eot_set", b1.eot, 1);
        b1.if_req = 1'b1; b1.if_addr = 16'h0004;
        tick();
        b1.if_req = 1'b0;
        tick();
        tick();
        chk("eot_traffic_rdata", b1.if_rdata, 16'h1234);
        chk("eot_sticky", b1.eot, 1);

        // Reset during WAIT with MEM_LAT=3
        b3.if_req = 1'b1; b3.if_addr = 16'h0030;
        tick();
        chk("rmr_gnt", b3.if_gnt, 1);
        b3.if_req = 1'b0;
        tick();
        chk("rmr_wait_rv", b3.if_rvalid, 0);
        rst_n = 1'b0;
        #1;
        chk("rmr_rst_en",  b3.mem_en, 0);
        chk("rmr_rst_rv",  b3.if_rvalid, 0);
        chk("rmr_eot_clr", b1.eot, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rmr_no_rvalid", b3.if_rvalid, 0);
        end
        b3.if_req = 1'b1; b3.if_addr = 16'h0031;
        tick();
        chk("rmr_new_gnt",  b3.if_gnt, 1);
        chk("rmr_new_addr", b3.mem_addr, 16'h0031);
        b3.if_req = 1'b0;
        repeat (3) tick();
        chk("rmr_new_rv_early", b3.if_rvalid, 0);
        tick();
        chk("rmr_new_rvalid", b3.if_rvalid, 1);
        chk("rmr_new_rdata",  b3.if_rdata, 16'ha031);
        tick();
        chk("rmr_new_rv_pulse", b3.if_rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/manta_mem_arbiter.md
Name: manta_mem_arbiter

Overview:
- Arbiter and sequencer for the manta_style single-ported 16-bit memory.
- Shares the memory between two requesters: instruction fetch (IF port) and the MEM-stage load/store unit (DM port).
- Handles memory read latency and returns read data to the requester that issued the read.
- Also detects the end-of-test store (write of EOT_DATA to EOT_ADDR) and raises a sticky eot flag for benches and the halt logic.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..4
STARVE_MAX, 3, consecutive contended DM wins before IF is forced to win
EOT_ADDR, 16'hd074, end-of-test store address
EOT_DATA, 16'hd074, end-of-test store data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle grant pulse to IF
if_rvalid  out  1  one-cycle fetch-data-valid pulse
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  one-cycle grant pulse to DM
dm_rvalid  out  1  one-cycle load-data-valid pulse (loads only)
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
eot  out  1  sticky end-of-test flag

Behaviour:
- Async reset (rst_n=0): state=IDLE, starvation counter=0, all outputs 0 (including eot and both rdata buses).
- Reset mid-transaction aborts the access; no rvalid is produced for it.
- All outputs are registered.
- FSM states:
  - IDLE
  - ACCESS (exactly 1 cycle)
  - WAIT (reads only; MEM_LAT cycles)
- IDLE -> ACCESS, on a clock edge with if_req|dm_req:
  - Winner chosen, winner's address/data/we latched.
  - Later changes to req or addr do not affect this transaction.
- ACCESS cycle:
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the latch.
  - Winner's gnt=1 for this cycle only; the requester may drop req or present a new request afterwards.
  - For a store: mem_we=1 and next state is IDLE.
  - For a read (any IF access, or DM with we=0): next state is WAIT.
- WAIT:
  - Counts MEM_LAT cycles.
  - On the edge where mem_rdata is valid (MEM_LAT cycles after ACCESS), mem_rdata is captured into the winner's rdata.
  - Winner's rvalid=1 for exactly the following cycle; state returns to IDLE on that same edge.
  - The other port's rdata holds its previous value.
- Timing:
  - Read with ACCESS at cycle t: rvalid at t+MEM_LAT+1; earliest next ACCESS at t+MEM_LAT+2.
  - Store with ACCESS at cycle t: earliest next ACCESS at t+2.
- Requests arriving outside IDLE wait; they are arbitrated at the first IDLE edge.
- Arbitration:
  - Single requester always wins.
  - Both requesting: DM wins (older instruction) unless starvation counter == STARVE_MAX, in which case IF wins.
  - Counter increments on each contended DM win, saturating at STARVE_MAX.
  - Counter clears whenever IF wins.
  - Uncontended DM wins leave the counter unchanged.
- mem_en, mem_we and gnt are 0 in every cycle other than ACCESS. In those cycles mem_addr and mem_wdata hold their last values.
- eot:
  - Set on the edge ending an ACCESS cycle that is a DM store with addr==EOT_ADDR and wdata==EOT_DATA.
  - Stays set until reset.
  - A matching address with other data, or a matching load, does not set it.
- Address and data widths are passed through unmodified; there is no arithmetic beyond the 2-bit counter and the latency counter. The latency counter must not wrap into a second rvalid.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then 1 with no requests -> all outputs 0 and mem_en never asserted.
- IF read, MEM_LAT=1: if_req, addr 16'h0004, memory returns 16'h1234 -> if_gnt and mem_en at cycle t, if_rvalid=1 with if_rdata=16'h1234 at t+2, single pulse.
- DM store: dm_we=1, addr 16'h0100, wdata 16'hbeef -> mem_we=1, mem_addr=16'h0100, mem_wdata=16'hbeef for one cycle, no dm_rvalid, next grant possible at t+2.
- Contention: if_req and dm_req (loads) held continuously -> grant order DM, DM, DM, IF, DM, DM, DM, IF..., each read returned to the correct port.
- EOT: DM store 16'hd074 to 16'hd073 -> eot stays 0; DM store 16'hd074 to 16'hd074 -> eot=1 the next cycle and remains 1 through later traffic.
- Reset mid-read: MEM_LAT=3, rst_n pulsed low during WAIT -> no rvalid, state IDLE, a new IF request is served normally afterwards.
